// File: rtl/juggle_pkg.sv
// juggle_pkg: shared constants and types for the siteswap throw scheduler.
//   MAX_LEN       maximum pattern length
//   RING_DEPTH    landing ring slots (must exceed MAX_HEIGHT)
//   MAX_HEIGHT    tallest legal throw
//   sched_state_t scheduler FSM states
//   slot_t        one landing ring slot: occupied flag + ball id
package juggle_pkg;

    localparam int unsigned MAX_LEN    = 7;
    localparam int unsigned RING_DEPTH = 8;
    localparam int unsigned MAX_HEIGHT = 7;
    localparam int unsigned PTR_W      = $clog2(RING_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        ERROR
    } sched_state_t;

    typedef struct packed {
        logic       occ;
        logic [2:0] ball;
    } slot_t;

    // Pattern index advance, wrapping to 0 after the last valid entry.
    function automatic logic [2:0] next_idx(input logic [2:0] idx, input logic [2:0] len);
        logic [3:0] inc;
        inc = {1'b0, idx} + 4'd1;
        return (inc >= {1'b0, len}) ? 3'd0 : inc[2:0];
    endfunction

endpackage

// File: rtl/landing_ring.sv
// landing_ring: circular schedule of which ball lands on which future beat.
// Slot at the head pointer is the current beat; slot head+k lands k beats later.
//   clk_in      clock
//   rst_in      synchronous active-high reset (empties ring, head to 0)
//   clear       flush: empty every slot and return head to 0
//   advance     end of beat: empty the head slot and step head
//   write_en    mark slot head+offset occupied by ball
//   offset      distance from head of the slot to write / probe (throw height)
//   ball        ball id to store
//   head_slot   contents of the current (head) slot
//   target_occ  occupancy of slot head+offset
module landing_ring
    import juggle_pkg::*;
(
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       clear,
    input  logic       advance,
    input  logic       write_en,
    input  logic [2:0] offset,
    input  logic [2:0] ball,
    output slot_t      head_slot,
    output logic       target_occ
);

    slot_t            ring_q [RING_DEPTH];
    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] target;

    // Ring depth is a power of two, so the pointer add wraps naturally.
    assign target     = head_q + PTR_W'(offset);
    assign head_slot  = ring_q[head_q];
    assign target_occ = ring_q[target].occ;

    always_ff @(posedge clk_in) begin
        if (rst_in || clear) begin
            for (int i = 0; i < RING_DEPTH; i++) begin
                ring_q[i] <= '0;
            end
            head_q <= '0;
        end else begin
            // Heights are 1..7 on writes, so target never aliases head here.
            if (write_en) begin
                ring_q[target] <= '{occ: 1'b1, ball: ball};
            end
            if (advance) begin
                ring_q[head_q].occ <= 1'b0;
                head_q             <= head_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/throw_scheduler.sv
// throw_scheduler: turns a latched siteswap pattern into per-beat throw events.
//   clk_in, rst_in          clock, synchronous active-high reset
//   new_beat                one-cycle beat strobe
//   pattern_in              7 x 3-bit throw heights, entry 0 thrown first
//   pattern_length          number of valid entries (1..7)
//   num_balls_in            ball count of the pattern
//   pattern_valid_in        pattern inputs are legal (sampled in IDLE)
//   stop_in                 abort, return to IDLE
//   throw_valid_out         one-cycle pulse per issued throw
//   throw_ball_out          ball thrown (held between throws)
//   throw_height_out        height thrown (held between throws)
//   throw_hand_out          hand thrown from, 0 left / 1 right (held between throws)
//   running_out             high while running
//   error_out               sticky collision / dropped-ball flag
module throw_scheduler
    import juggle_pkg::*;
(
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     new_beat,
    input  logic [MAX_LEN-1:0][2:0]  pattern_in,
    input  logic [2:0]               pattern_length,
    input  logic [2:0]               num_balls_in,
    input  logic                     pattern_valid_in,
    input  logic                     stop_in,
    output logic                     throw_valid_out,
    output logic [2:0]               throw_ball_out,
    output logic [2:0]               throw_height_out,
    output logic                     throw_hand_out,
    output logic                     running_out,
    output logic                     error_out
);

    sched_state_t             state_q, state_d;
    logic [MAX_LEN-1:0][2:0]  pat_q, pat_d;
    logic [2:0]               len_q, len_d;
    logic [2:0]               nballs_q, nballs_d;
    logic [2:0]               idx_q, idx_d;
    logic [2:0]               launched_q, launched_d;
    logic                     hand_q, hand_d;
    logic                     valid_q, valid_d;
    logic [2:0]               ball_q, ball_d;
    logic [2:0]               height_q, height_d;
    logic                     hand_out_q, hand_out_d;

    logic       ring_clear;
    logic       ring_write;
    logic       ring_advance;
    logic [2:0] ring_ball;
    slot_t      head_slot;
    logic       target_occ;
    logic [2:0] cur_h;
    logic [2:0] sel_ball;
    logic       fault;

    assign cur_h = pat_q[idx_q];

    // Ring only holds meaningful state while running; keep it flushed otherwise.
    assign ring_clear = stop_in || (state_q != RUN);

    landing_ring u_ring (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .clear      (ring_clear),
        .advance    (ring_advance),
        .write_en   (ring_write),
        .offset     (cur_h),
        .ball       (ring_ball),
        .head_slot  (head_slot),
        .target_occ (target_occ)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            pat_q      <= '0;
            len_q      <= '0;
            nballs_q   <= '0;
            idx_q      <= '0;
            launched_q <= '0;
            hand_q     <= 1'b0;
            valid_q    <= 1'b0;
            ball_q     <= '0;
            height_q   <= '0;
            hand_out_q <= 1'b0;
        end else begin
            pat_q      <= pat_d;
            len_q      <= len_d;
            nballs_q   <= nballs_d;
            idx_q      <= idx_d;
            launched_q <= launched_d;
            hand_q     <= hand_d;
            valid_q    <= valid_d;
            ball_q     <= ball_d;
            height_q   <= height_d;
            hand_out_q <= hand_out_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pat_d        = pat_q;
        len_d        = len_q;
        nballs_d     = nballs_q;
        idx_d        = idx_q;
        launched_d   = launched_q;
        hand_d       = hand_q;
        valid_d      = 1'b0;
        ball_d       = ball_q;
        height_d     = height_q;
        hand_out_d   = hand_out_q;
        ring_write   = 1'b0;
        ring_advance = 1'b0;
        ring_ball    = '0;
        sel_ball     = '0;
        fault        = 1'b0;

        case (state_q)
            IDLE: begin
                if (pattern_valid_in && (pattern_length != 3'd0)) begin
                    pat_d      = pattern_in;
                    len_d      = pattern_length;
                    nballs_d   = num_balls_in;
                    idx_d      = '0;
                    launched_d = '0;
                    hand_d     = 1'b0;
                    state_d    = RUN;
                end
            end
            RUN: begin
                if (new_beat && !stop_in) begin
                    if (cur_h == 3'd0) begin
                        // A ball landing on a 0-beat has nowhere to go.
                        fault = head_slot.occ;
                    end else begin
                        // Reuse the landing ball first; new balls enter only on empty beats.
                        if (head_slot.occ) begin
                            sel_ball = head_slot.ball;
                        end else if (launched_q < nballs_q) begin
                            sel_ball   = launched_q;
                            launched_d = launched_q + 3'd1;
                        end else begin
                            fault = 1'b1;
                        end
                        if (target_occ) begin
                            fault = 1'b1;
                        end
                    end

                    ring_advance = 1'b1;
                    idx_d        = next_idx(idx_q, len_q);
                    hand_d       = ~hand_q;

                    if (fault) begin
                        state_d = ERROR;
                    end else if (cur_h != 3'd0) begin
                        ring_write = 1'b1;
                        ring_ball  = sel_ball;
                        valid_d    = 1'b1;
                        ball_d     = sel_ball;
                        height_d   = cur_h;
                        hand_out_d = hand_q;
                    end
                end
            end
            ERROR: begin
            end
            default: state_d = IDLE;
        endcase

        // Stop overrides everything, including a coincident beat.
        if (stop_in) begin
            state_d      = IDLE;
            valid_d      = 1'b0;
            idx_d        = '0;
            launched_d   = '0;
            hand_d       = 1'b0;
            ring_write   = 1'b0;
            ring_advance = 1'b0;
        end
    end

    assign throw_valid_out  = valid_q;
    assign throw_ball_out   = ball_q;
    assign throw_height_out = height_q;
    assign throw_hand_out   = hand_out_q;
    assign running_out      = (state_q == RUN);
    assign error_out        = (state_q == ERROR);

endmodule

// File: tb/tb_throw_scheduler.sv
// Bench for throw_scheduler: a ball-flight model (absolute landing beat per ball)
// predicts every output each cycle; directed runs pin the model to known sequences.
module tb_throw_scheduler;

    logic            clk_in = 1'b0;
    logic            rst_in;
    logic            new_beat;
    logic [6:0][2:0] pattern_in;
    logic [2:0]      pattern_length;
    logic [2:0]      num_balls_in;
    logic            pattern_valid_in;
    logic            stop_in;
    logic            throw_valid_out;
    logic [2:0]      throw_ball_out;
    logic [2:0]      throw_height_out;
    logic            throw_hand_out;
    logic            running_out;
    logic            error_out;

    throw_scheduler dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .new_beat         (new_beat),
        .pattern_in       (pattern_in),
        .pattern_length   (pattern_length),
        .num_balls_in     (num_balls_in),
        .pattern_valid_in (pattern_valid_in),
        .stop_in          (stop_in),
        .throw_valid_out  (throw_valid_out),
        .throw_ball_out   (throw_ball_out),
        .throw_height_out (throw_height_out),
        .throw_hand_out   (throw_hand_out),
        .running_out      (running_out),
        .error_out        (error_out)
    );

    always #5 clk_in = ~clk_in;

    int vectors     = 0;
    int miscompares = 0;
    bit cmp_en      = 1'b0;

    // Model: mode 0 idle, 1 running, 2 error. m_land[b] = beat on which ball b lands.
    int   m_mode;
    int   m_pat[7];
    int   m_len, m_nb, m_t, m_launched;
    int   m_land[8];
    logic e_valid, e_hand;
    logic [2:0] e_ball, e_height;
    int   log_ball[$];
    int   log_h[$];
    int   log_hand[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_t = 0;
        m_launched = 0;
        for (int b = 0; b < 8; b++) m_land[b] = -1;
    endtask

    task automatic model_beat();
        int  h, landing, b;
        bit  f;
        h = m_pat[m_t % m_len];
        landing = -1;
        for (int c = 0; c < 8; c++) if (m_land[c] == m_t) landing = c;
        f = 1'b0;
        b = -1;
        if (h == 0) begin
            if (landing >= 0) f = 1'b1;
        end else begin
            if (landing >= 0) b = landing;
            else if (m_launched < m_nb) begin
                b = m_launched;
                m_launched++;
            end else f = 1'b1;
            for (int c = 0; c < 8; c++) if (m_land[c] == m_t + h) f = 1'b1;
            if (!f) begin
                m_land[b] = m_t + h;
                e_valid   = 1'b1;
                e_ball    = 3'(b);
                e_height  = 3'(h);
                e_hand    = m_t[0];
                log_ball.push_back(b);
                log_h.push_back(h);
                log_hand.push_back(m_t % 2);
            end
        end
        if (f) m_mode = 2;
        m_t++;
    endtask

    task automatic model_step();
        e_valid = 1'b0;
        if (rst_in) begin
            m_mode = 0;
            e_ball = '0;
            e_height = '0;
            e_hand = 1'b0;
            model_clear();
        end else if (stop_in) begin
            m_mode = 0;
            model_clear();
        end else if (m_mode == 0) begin
            if (pattern_valid_in && pattern_length != 0) begin
                for (int i = 0; i < 7; i++) m_pat[i] = int'(pattern_in[i]);
                m_len  = int'(pattern_length);
                m_nb   = int'(num_balls_in);
                m_mode = 1;
                model_clear();
            end
        end else if (m_mode == 1) begin
            if (new_beat) model_beat();
        end
    endtask

    initial forever begin
        @(posedge clk_in);
        model_step();
    end

    initial forever begin
        @(negedge clk_in);
        if (cmp_en) begin
            chk("valid", 32'(throw_valid_out), 32'(e_valid));
            chk("ball", 32'(throw_ball_out), 32'(e_ball));
            chk("height", 32'(throw_height_out), 32'(e_height));
            chk("hand", 32'(throw_hand_out), 32'(e_hand));
            chk("running", 32'(running_out), 32'(m_mode == 1));
            chk("error", 32'(error_out), 32'(m_mode == 2));
        end
    end

    task automatic stop_pulse();
        @(negedge clk_in);
        stop_in = 1'b1;
        @(negedge clk_in);
        stop_in = 1'b0;
    endtask

    task automatic load(input int p[7], input int len, input int nb);
        @(negedge clk_in);
        for (int i = 0; i < 7; i++) pattern_in[i] = 3'(p[i]);
        pattern_length   = 3'(len);
        num_balls_in     = 3'(nb);
        pattern_valid_in = 1'b1;
        @(negedge clk_in);
        pattern_valid_in = 1'b0;
        log_ball.delete();
        log_h.delete();
        log_hand.delete();
    endtask

    task automatic beats(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_in);
            new_beat = 1'b1;
            @(negedge clk_in);
            new_beat = 1'b0;
        end
    endtask

    int p3[7]    = '{3, 0, 0, 0, 0, 0, 0};
    int p441[7]  = '{4, 4, 1, 0, 0, 0, 0};
    int p43[7]   = '{4, 3, 0, 0, 0, 0, 0};
    int p5[7]    = '{5, 0, 0, 0, 0, 0, 0};
    int p0[7]    = '{0, 0, 0, 0, 0, 0, 0};
    int vt[6][7] = '{'{3, 0, 0, 0, 0, 0, 0}, '{4, 4, 1, 0, 0, 0, 0},
                     '{5, 3, 1, 0, 0, 0, 0}, '{4, 2, 3, 0, 0, 0, 0},
                     '{5, 1, 0, 0, 0, 0, 0}, '{7, 5, 3, 1, 0, 0, 0}};
    int vlen[6]  = '{1, 3, 3, 3, 2, 4};
    int vnb[6]   = '{3, 3, 3, 3, 3, 4};

    initial begin
        int exp_b1[7]  = '{0, 1, 2, 0, 1, 2, 0};
        int exp_b2[7]  = '{0, 1, 2, 2, 0, 1, 1};
        int exp_h2[7]  = '{4, 4, 1, 4, 4, 1, 4};
        int rp[7];
        int sel, len, nb;

        rst_in = 1'b1;
        new_beat = 1'b0;
        pattern_in = '0;
        pattern_length = '0;
        num_balls_in = '0;
        pattern_valid_in = 1'b0;
        stop_in = 1'b0;
        @(negedge clk_in);
        @(negedge clk_in);
        cmp_en = 1'b1;
        chk("reset_valid", 32'(throw_valid_out), 32'd0);
        chk("reset_running", 32'(running_out), 32'd0);
        rst_in = 1'b0;

        // {3}, 3 balls
        load(p3, 1, 3);
        beats(7);
        chk("p3_count", 32'(log_ball.size()), 32'd7);
        for (int i = 0; i < 7 && i < log_ball.size(); i++) begin
            chk("p3_ball", 32'(log_ball[i]), 32'(exp_b1[i]));
            chk("p3_height", 32'(log_h[i]), 32'd3);
            chk("p3_hand", 32'(log_hand[i]), 32'(i % 2));
        end
        chk("p3_error", 32'(error_out), 32'd0);
        stop_pulse();

        // {4,4,1}, 3 balls
        load(p441, 3, 3);
        beats(7);
        chk("p441_count", 32'(log_ball.size()), 32'd7);
        for (int i = 0; i < 7 && i < log_ball.size(); i++) begin
            chk("p441_ball", 32'(log_ball[i]), 32'(exp_b2[i]));
            chk("p441_height", 32'(log_h[i]), 32'(exp_h2[i]));
        end
        stop_pulse();

        // {4,3} collides on second beat
        load(p43, 2, 3);
        beats(2);
        chk("p43_count", 32'(log_ball.size()), 32'd1);
        chk("p43_error", 32'(error_out), 32'd1);
        chk("p43_running", 32'(running_out), 32'd0);
        beats(2);
        stop_pulse();
        chk("p43_cleared", 32'(error_out), 32'd0);

        // Reset mid-run, then relaunch starts at ball 0
        load(p3, 1, 3);
        beats(2);
        @(negedge clk_in);
        rst_in = 1'b1;
        @(negedge clk_in);
        rst_in = 1'b0;
        chk("rst_ball", 32'(throw_ball_out), 32'd0);
        chk("rst_height", 32'(throw_height_out), 32'd0);
        chk("rst_running", 32'(running_out), 32'd0);
        load(p3, 1, 3);
        beats(2);
        chk("relaunch_ball0", 32'(log_ball[0]), 32'd0);
        chk("relaunch_dut_ball", 32'(throw_ball_out), 32'd1);
        stop_pulse();

        // Inputs frozen while running; stop beats a coincident beat
        load(p3, 1, 3);
        beats(1);
        @(negedge clk_in);
        pattern_in[0] = 3'd5;
        num_balls_in  = 3'd5;
        beats(2);
        chk("frozen_count", 32'(log_h.size()), 32'd3);
        for (int i = 0; i < log_h.size(); i++) chk("frozen_height", 32'(log_h[i]), 32'd3);
        @(negedge clk_in);
        stop_in  = 1'b1;
        new_beat = 1'b1;
        @(negedge clk_in);
        stop_in  = 1'b0;
        new_beat = 1'b0;
        chk("stopbeat_valid", 32'(throw_valid_out), 32'd0);
        load(p5, 1, 5);
        beats(1);
        chk("p5_height", 32'(throw_height_out), 32'd5);
        stop_pulse();

        // All-zero pattern with no balls
        load(p0, 1, 0);
        beats(4);
        chk("p0_count", 32'(log_ball.size()), 32'd0);
        chk("p0_running", 32'(running_out), 32'd1);
        chk("p0_error", 32'(error_out), 32'd0);
        stop_pulse();

        // Randomised runs: valid patterns mixed with arbitrary ones
        for (int r = 0; r < 60; r++) begin
            if ($urandom_range(0, 2) == 0) begin
                for (int i = 0; i < 7; i++) rp[i] = int'($urandom_range(0, 7));
                len = int'($urandom_range(0, 7));
                nb  = int'($urandom_range(0, 7));
            end else begin
                sel = int'($urandom_range(0, 5));
                for (int i = 0; i < 7; i++) rp[i] = vt[sel][i];
                len = vlen[sel];
                nb  = vnb[sel];
            end
            load(rp, len, nb);
            for (int c = 0; c < 30; c++) begin
                @(negedge clk_in);
                new_beat         = 1'($urandom_range(0, 1));
                stop_in          = ($urandom_range(0, 49) == 0);
                pattern_valid_in = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 7) == 0) pattern_in[$urandom_range(0, 6)] = 3'($urandom);
                if ($urandom_range(0, 99) == 0) rst_in = 1'b1;
                else rst_in = 1'b0;
            end
            @(negedge clk_in);
            new_beat = 1'b0;
            pattern_valid_in = 1'b0;
            rst_in = 1'b0;
            stop_pulse();
        end

        @(negedge clk_in);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
